// File: rtl/cp0_exception_ctrl.sv
// Exception/interrupt sequencer for CP0: flushes the pipeline, serialises the
// EPC/Cause/Status updates through the single CP0 write port, then redirects fetch.
module cp0_exception_ctrl #(
   parameter logic [31:0] EXC_VECTOR       = 32'h0000_0020,
   parameter bit          COUNT_DELAY_SLOT = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] exc_type_input,
   input  logic [31:0] exc_pc_input,
   input  logic        exc_in_delay_slot_input,
   input  logic        mem_valid_input,
   input  logic        stall_input,
   input  logic [31:0] status_input,
   input  logic [31:0] cause_input,
   input  logic [31:0] epc_input,
   input  logic        wb_cp0_we_input,
   input  logic [4:0]  wb_cp0_addr_input,
   input  logic [31:0] wb_cp0_data_input,
   output logic        cp0_we_output,
   output logic [4:0]  cp0_waddr_output,
   output logic [31:0] cp0_wdata_output,
   output logic        cp0_exc_write_output,
   output logic        flush_output,
   output logic        stall_request_output,
   output logic        redirect_valid_output,
   output logic [31:0] new_pc_output,
   output logic        busy_output
);

   localparam logic [4:0] ADDR_STATUS = 5'd12;
   localparam logic [4:0] ADDR_CAUSE  = 5'd13;
   localparam logic [4:0] ADDR_EPC    = 5'd14;

   localparam logic [4:0] CODE_INT = 5'd0;
   localparam logic [4:0] CODE_SYS = 5'd8;
   localparam logic [4:0] CODE_RI  = 5'd10;
   localparam logic [4:0] CODE_OV  = 5'd12;
   localparam logic [4:0] CODE_TR  = 5'd13;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_WR_EPC,
      S_WR_CAUSE,
      S_WR_STATUS,
      S_REDIRECT
   } state_t;

   state_t      r_state;
   logic [4:0]  r_exc_code;
   logic [31:0] r_pc;
   logic        r_bd;
   logic        r_eret;
   logic [31:0] r_status;
   logic        r_flush;
   logic        r_stall_req;
   logic        r_redirect;
   logic [31:0] r_new_pc;
   logic        r_busy;

   logic [31:0] w_eff_status;
   logic        w_int_pending;
   logic        w_event;
   logic        w_accept;
   logic [4:0]  w_exc_code;
   logic        w_is_eret;
   logic        w_we;
   logic [4:0]  w_waddr;
   logic [31:0] w_wdata;
   logic        w_exc_write;
   logic        w_unused;

   assign w_unused = ^{exc_type_input[31:13], exc_type_input[7:0]};

   // An mtc0 to Status in the same cycle is older than the MEM instruction.
   assign w_eff_status  = (wb_cp0_we_input && (wb_cp0_addr_input == ADDR_STATUS))
                          ? wb_cp0_data_input : status_input;
   assign w_int_pending = w_eff_status[0] & ~w_eff_status[1]
                          & (|(cause_input[15:10] & w_eff_status[15:10]));
   assign w_event       = w_int_pending | (|exc_type_input[12:8]);
   assign w_accept      = (r_state == S_IDLE) & mem_valid_input & ~stall_input & w_event;

   // Event priority: interrupt, syscall, invalid, trap, overflow, eret.
   always_comb begin
      w_exc_code = CODE_INT;
      w_is_eret  = 1'b0;
      if (w_int_pending)          w_exc_code = CODE_INT;
      else if (exc_type_input[8])  w_exc_code = CODE_SYS;
      else if (exc_type_input[9])  w_exc_code = CODE_RI;
      else if (exc_type_input[10]) w_exc_code = CODE_TR;
      else if (exc_type_input[11]) w_exc_code = CODE_OV;
      else if (exc_type_input[12]) w_is_eret  = 1'b1;
   end

   // Sequencer state, latched event context and registered control outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_exc_code  <= 5'd0;
         r_pc        <= 32'd0;
         r_bd        <= 1'b0;
         r_eret      <= 1'b0;
         r_status    <= 32'd0;
         r_flush     <= 1'b0;
         r_stall_req <= 1'b0;
         r_redirect  <= 1'b0;
         r_new_pc    <= 32'd0;
         r_busy      <= 1'b0;
      end else begin
         r_flush    <= 1'b0;
         r_redirect <= 1'b0;
         r_new_pc   <= 32'd0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state     <= S_FLUSH;
                  r_exc_code  <= w_exc_code;
                  r_pc        <= exc_pc_input;
                  r_bd        <= exc_in_delay_slot_input & COUNT_DELAY_SLOT;
                  r_eret      <= w_is_eret;
                  r_status    <= w_eff_status;
                  r_flush     <= 1'b1;
                  r_stall_req <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            S_FLUSH: begin
               // Nested exceptions (EXL already set) keep the original EPC and BD.
               if (r_eret)           r_state <= S_WR_STATUS;
               else if (r_status[1]) r_state <= S_WR_CAUSE;
               else                  r_state <= S_WR_EPC;
            end
            S_WR_EPC:   r_state <= S_WR_CAUSE;
            S_WR_CAUSE: r_state <= S_WR_STATUS;
            S_WR_STATUS: begin
               r_state     <= S_REDIRECT;
               r_stall_req <= 1'b0;
               r_redirect  <= 1'b1;
               r_new_pc    <= r_eret ? epc_input : EXC_VECTOR;
            end
            S_REDIRECT: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_stall_req <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   // CP0 write-port mux: mtc0 owns it in IDLE, the sequencer owns it otherwise.
   always_comb begin
      w_we        = 1'b0;
      w_waddr     = 5'd0;
      w_wdata     = 32'd0;
      w_exc_write = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_we    = wb_cp0_we_input;
            w_waddr = wb_cp0_addr_input;
            w_wdata = wb_cp0_data_input;
         end
         S_WR_EPC: begin
            w_we    = 1'b1;
            w_waddr = ADDR_EPC;
            w_wdata = r_bd ? (r_pc - 32'd4) : r_pc;
         end
         S_WR_CAUSE: begin
            w_we        = 1'b1;
            w_waddr     = ADDR_CAUSE;
            w_exc_write = 1'b1;
            w_wdata     = cause_input;
            if (!r_status[1]) w_wdata[31] = r_bd;
            w_wdata[6:2] = r_exc_code;
         end
         S_WR_STATUS: begin
            w_we       = 1'b1;
            w_waddr    = ADDR_STATUS;
            w_wdata    = r_status;
            w_wdata[1] = ~r_eret;
         end
         default: begin
            w_we = 1'b0;
         end
      endcase
   end

   assign cp0_we_output         = w_we & ~reset;
   assign cp0_waddr_output      = reset ? 5'd0 : w_waddr;
   assign cp0_wdata_output      = reset ? 32'd0 : w_wdata;
   assign cp0_exc_write_output  = w_exc_write & ~reset;
   assign flush_output          = r_flush;
   assign stall_request_output  = r_stall_req;
   assign redirect_valid_output = r_redirect;
   assign new_pc_output         = r_new_pc;
   assign busy_output           = r_busy;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Directed cycle-by-cycle bench for cp0_exception_ctrl: one table row per clock,
// expected outputs hand-computed, plus a reset-abort sequence.
module tb_cp0_exception_ctrl;

   logic        clock;
   logic        reset;
   logic [31:0] exc_type_input;
   logic [31:0] exc_pc_input;
   logic        exc_in_delay_slot_input;
   logic        mem_valid_input;
   logic        stall_input;
   logic [31:0] status_input;
   logic [31:0] cause_input;
   logic [31:0] epc_input;
   logic        wb_cp0_we_input;
   logic [4:0]  wb_cp0_addr_input;
   logic [31:0] wb_cp0_data_input;
   logic        cp0_we_output;
   logic [4:0]  cp0_waddr_output;
   logic [31:0] cp0_wdata_output;
   logic        cp0_exc_write_output;
   logic        flush_output;
   logic        stall_request_output;
   logic        redirect_valid_output;
   logic [31:0] new_pc_output;
   logic        busy_output;

   cp0_exception_ctrl dut (
      .clock                   (clock),
      .reset                   (reset),
      .exc_type_input          (exc_type_input),
      .exc_pc_input            (exc_pc_input),
      .exc_in_delay_slot_input (exc_in_delay_slot_input),
      .mem_valid_input         (mem_valid_input),
      .stall_input             (stall_input),
      .status_input            (status_input),
      .cause_input             (cause_input),
      .epc_input               (epc_input),
      .wb_cp0_we_input         (wb_cp0_we_input),
      .wb_cp0_addr_input       (wb_cp0_addr_input),
      .wb_cp0_data_input       (wb_cp0_data_input),
      .cp0_we_output           (cp0_we_output),
      .cp0_waddr_output        (cp0_waddr_output),
      .cp0_wdata_output        (cp0_wdata_output),
      .cp0_exc_write_output    (cp0_exc_write_output),
      .flush_output            (flush_output),
      .stall_request_output    (stall_request_output),
      .redirect_valid_output   (redirect_valid_output),
      .new_pc_output           (new_pc_output),
      .busy_output             (busy_output)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {we, waddr, wdata, exc_write, flush, stall_req, redirect, new_pc, busy}
   logic [74:0] obs;
   assign obs = {cp0_we_output, cp0_waddr_output, cp0_wdata_output, cp0_exc_write_output,
                 flush_output, stall_request_output, redirect_valid_output,
                 new_pc_output, busy_output};

   typedef struct {
      string       name;
      logic [31:0] exc;
      logic [31:0] pc;
      logic        ds;
      logic        mv;
      logic        st;
      logic [31:0] status;
      logic [31:0] cause;
      logic [31:0] epc;
      logic        wwe;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [74:0] exp;
   } vec_t;

   vec_t vecs[$];
   vec_t s;
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [74:0] mk(logic we, logic [4:0] wa, logic [31:0] wd, logic excw,
                                      logic fl, logic stl, logic rd, logic [31:0] npc,
                                      logic busy);
      return {we, wa, wd, excw, fl, stl, rd, npc, busy};
   endfunction

   task automatic stage(input logic [31:0] exc, input logic [31:0] pc, input logic ds,
                        input logic mv, input logic st, input logic [31:0] status,
                        input logic [31:0] cause, input logic [31:0] epc, input logic wwe,
                        input logic [4:0] wa, input logic [31:0] wd);
      s.exc = exc; s.pc = pc; s.ds = ds; s.mv = mv; s.st = st;
      s.status = status; s.cause = cause; s.epc = epc;
      s.wwe = wwe; s.wa = wa; s.wd = wd;
   endtask

   task automatic quiet();
      s.exc = 32'd0; s.mv = 1'b0; s.ds = 1'b0; s.st = 1'b0;
      s.wwe = 1'b0; s.wa = 5'd0; s.wd = 32'd0;
   endtask

   task automatic add(input string name, input logic [74:0] exp);
      vec_t v;
      v = s;
      v.name = name;
      v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic add_idle(input string name);
      add(name, mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
   endtask
   task automatic add_flush(input string name);
      add(name, mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1));
   endtask
   task automatic add_wr(input string name, input logic [4:0] wa, input logic [31:0] wd,
                         input logic excw);
      add(name, mk(1'b1, wa, wd, excw, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1));
   endtask
   task automatic add_redir(input string name, input logic [31:0] npc);
      add(name, mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, npc, 1'b1));
   endtask
   task automatic add_pass(input string name, input logic [4:0] wa, input logic [31:0] wd);
      add(name, mk(1'b1, wa, wd, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
   endtask

   task automatic drive(input vec_t v);
      exc_type_input          = v.exc;
      exc_pc_input            = v.pc;
      exc_in_delay_slot_input = v.ds;
      mem_valid_input         = v.mv;
      stall_input             = v.st;
      status_input            = v.status;
      cause_input             = v.cause;
      epc_input               = v.epc;
      wb_cp0_we_input         = v.wwe;
      wb_cp0_addr_input       = v.wa;
      wb_cp0_data_input       = v.wd;
   endtask

   task automatic check(input string name, input logic [74:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, obs, exp);
      end
   endtask

   // Drive staged inputs just after the edge, check mid-cycle.
   task automatic cyc(input string name, input logic [74:0] exp);
      @(posedge clock);
      #1;
      drive(s);
      #3;
      check(name, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests so far %0d", n_tests);
      $fatal(1);
   end

   initial begin
      stage(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      add_idle("idle_after_reset");

      // Syscall, normal path; a new event during WR_EPC must be ignored.
      stage(32'h100, 32'h100, 1'b0, 1'b1, 1'b0, 32'h1000_0001, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      add_idle("sys_accept");
      quiet(); add_flush("sys_flush");
      s.exc = 32'h100; s.mv = 1'b1;
      add_wr("sys_epc", 5'd14, 32'h100, 1'b0);
      quiet();
      add_wr("sys_cause", 5'd13, 32'h20, 1'b1);
      add_wr("sys_status", 5'd12, 32'h1000_0003, 1'b0);
      add_redir("sys_redirect", 32'h20);
      add_idle("sys_done");

      // Overflow in a delay slot.
      stage(32'h800, 32'h204, 1'b1, 1'b1, 1'b0, 32'h1000_0001, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      add_idle("ovf_accept");
      quiet(); add_flush("ovf_flush");
      add_wr("ovf_epc", 5'd14, 32'h200, 1'b0);
      add_wr("ovf_cause", 5'd13, 32'h8000_0030, 1'b1);
      add_wr("ovf_status", 5'd12, 32'h1000_0003, 1'b0);
      add_redir("ovf_redirect", 32'h20);
      add_idle("ovf_done");

      // Interrupt beats overflow flagged in the same cycle.
      stage(32'h800, 32'h300, 1'b0, 1'b1, 1'b0, 32'h1000_0401, 32'h400, 32'd0, 1'b0, 5'd0, 32'd0);
      add_idle("int_accept");
      quiet(); add_flush("int_flush");
      add_wr("int_epc", 5'd14, 32'h300, 1'b0);
      add_wr("int_cause", 5'd13, 32'h400, 1'b1);
      add_wr("int_status", 5'd12, 32'h1000_0403, 1'b0);
      add_redir("int_redirect", 32'h20);
      add_idle("int_done");

      // Eret: only Status is written, then back to EPC.
      stage(32'h1000, 32'h1ac, 1'b0, 1'b1, 1'b0, 32'h1000_0003, 32'd0, 32'h180, 1'b0, 5'd0, 32'd0);
      add_idle("eret_accept");
      quiet(); add_flush("eret_flush");
      add_wr("eret_status", 5'd12, 32'h1000_0001, 1'b0);
      add_redir("eret_redirect", 32'h180);
      add_idle("eret_done");

      // mtc0 Status=0 masks a pending interrupt in the same cycle.
      stage(32'd0, 32'h320, 1'b0, 1'b1, 1'b0, 32'h1000_0401, 32'h400, 32'd0, 1'b1, 5'd12, 32'd0);
      add_pass("mtc0_masks_int", 5'd12, 32'd0);
      quiet(); add_idle("mtc0_no_accept");

      // Nested exception (EXL=1) in a delay slot: no EPC write, BD left alone.
      stage(32'h100, 32'h400, 1'b1, 1'b1, 1'b0, 32'h1000_0003, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      add_idle("exl_accept");
      quiet(); add_flush("exl_flush");
      add_wr("exl_cause", 5'd13, 32'h20, 1'b1);
      add_wr("exl_status", 5'd12, 32'h1000_0003, 1'b0);
      add_redir("exl_redirect", 32'h20);
      add_idle("exl_done");

      // Events not accepted: stalled, not valid, no flags.
      stage(32'h100, 32'h500, 1'b0, 1'b1, 1'b1, 32'h1000_0001, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      add_idle("stalled_event");
      s.st = 1'b0; s.mv = 1'b0;
      add_idle("invalid_slot_event");
      s.exc = 32'd0; s.mv = 1'b1;
      add_idle("no_flags");
      quiet(); add_idle("none_accepted");

      // Invalid+trap: invalid wins; mtc0 passes in the acceptance cycle, ignored when busy.
      stage(32'h600, 32'h500, 1'b0, 1'b1, 1'b0, 32'h1000_0001, 32'd0, 32'd0, 1'b1, 5'd9, 32'h1234);
      add_pass("ri_mtc0_pass", 5'd9, 32'h1234);
      quiet(); add_flush("ri_flush");
      s.wwe = 1'b1; s.wa = 5'd9; s.wd = 32'hdead;
      add_wr("ri_epc_mtc0_ignored", 5'd14, 32'h500, 1'b0);
      quiet();
      add_wr("ri_cause", 5'd13, 32'h28, 1'b1);
      add_wr("ri_status", 5'd12, 32'h1000_0003, 1'b0);
      add_redir("ri_redirect", 32'h20);
      add_idle("ri_done");

      // Trap+overflow: trap wins.
      stage(32'hc00, 32'h800, 1'b0, 1'b1, 1'b0, 32'h1000_0001, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      add_idle("tr_accept");
      quiet(); add_flush("tr_flush");
      add_wr("tr_epc", 5'd14, 32'h800, 1'b0);
      add_wr("tr_cause", 5'd13, 32'h34, 1'b1);
      add_wr("tr_status", 5'd12, 32'h1000_0003, 1'b0);
      add_redir("tr_redirect", 32'h20);
      add_idle("tr_done");

      // mtc0 to Status enables an interrupt via the bypass.
      stage(32'd0, 32'h600, 1'b0, 1'b1, 1'b0, 32'd0, 32'h400, 32'd0, 1'b1, 5'd12, 32'h1000_0401);
      add_pass("byp_accept", 5'd12, 32'h1000_0401);
      quiet(); add_flush("byp_flush");
      add_wr("byp_epc", 5'd14, 32'h600, 1'b0);
      add_wr("byp_cause", 5'd13, 32'h400, 1'b1);
      add_wr("byp_status", 5'd12, 32'h1000_0403, 1'b0);
      add_redir("byp_redirect", 32'h20);
      add_idle("byp_done");

      // Reset hold.
      reset = 1'b1;
      stage(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      drive(s);
      repeat (2) @(posedge clock);
      #4;
      check("reset_hold", mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
      reset = 1'b0;

      foreach (vecs[i]) begin
         @(posedge clock);
         #1;
         drive(vecs[i]);
         #3;
         check(vecs[i].name, vecs[i].exp);
      end

      // Reset asserted in WR_CAUSE aborts the sequence before the Status write.
      stage(32'h100, 32'h700, 1'b0, 1'b1, 1'b0, 32'h1000_0001, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      cyc("rst_accept", mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
      quiet();
      cyc("rst_flush", mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1));
      cyc("rst_epc", mk(1'b1, 5'd14, 32'h700, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1));
      cyc("rst_cause", mk(1'b1, 5'd13, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1));
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      #3;
      check("rst_aborted", mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
      cyc("rst_no_status_write", mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
